// File: rtl/noc_alloc_pkg.sv
// rtl/noc_alloc_pkg.sv - shared index-mapping and one-hot helpers for the switch allocator
package noc_alloc_pkg;

   localparam int MAX_W = 32;

   typedef enum logic [1:0] {
      FLIT_BODY   = 2'b00,
      FLIT_HEAD   = 2'b01,
      FLIT_TAIL   = 2'b10,
      FLIT_SINGLE = 2'b11
   } flit_kind_e;

   function automatic int calc_p_1(input int p, input bit self_loop_yes);
      return self_loop_yes ? p : p - 1;
   endfunction

   // Bit position of port o inside port j's vector once j's own slot is removed.
   function automatic int port_idx(input int j, input int o, input bit self_loop_yes);
      if (self_loop_yes) return o;
      return (o > j) ? o - 1 : o;
   endfunction

   function automatic logic [MAX_W-1:0] rot1(input logic [MAX_W-1:0] v, input int n);
      logic [MAX_W-1:0] mask;
      mask = '1;
      mask = mask >> (MAX_W - n);
      return ((v << 1) | (v >> (n - 1))) & mask;
   endfunction

endpackage

// File: rtl/pkt_lock_rr_arbiter.sv
// rtl/pkt_lock_rr_arbiter.sv - per-output round-robin arbiter with head-to-tail packet lock
// Optional conflict counter built when SW_ALLOC_STATS_EN is defined.
module pkt_lock_rr_arbiter
   import noc_alloc_pkg::*;
#(
   parameter int N = 4
`ifdef SW_ALLOC_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
)
(
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic [N-1:0] hdr,
   input  logic [N-1:0] tail,
   input  logic         ready,
   output logic [N-1:0] grant,
   output logic         locked
`ifdef SW_ALLOC_STATS_EN
   ,
   output logic [CNT_W-1:0] conflict_cnt
`endif
);

   logic         lock_q, lock_d;
   logic [N-1:0] owner_q, owner_d;
   logic [N-1:0] rr_ptr_q, rr_ptr_d;

   logic [N-1:0] eligible;
   logic [N-1:0] hi_elig;
   logic [N-1:0] pick;
   flit_kind_e   kind;

   // Search from rr_ptr upward first, then wrap to the lowest eligible bit.
   always_comb begin
      eligible = lock_q ? (req & owner_q) : (req & hdr);
      hi_elig  = eligible & ~(rr_ptr_q - N'(1));
      pick     = (|hi_elig) ? hi_elig : eligible;
      grant    = ready ? (pick & (~pick + N'(1))) : '0;
   end

   always_comb begin
      lock_d   = lock_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      kind     = flit_kind_e'({|(grant & tail), |(grant & hdr)});
      if (|grant) begin
         rr_ptr_d = N'(rot1(MAX_W'(grant), N));
         case (kind)
            FLIT_HEAD: begin
               lock_d  = 1'b1;
               owner_d = grant;
            end
            FLIT_TAIL, FLIT_SINGLE: begin
               lock_d  = 1'b0;
               owner_d = '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lock_q   <= 1'b0;
         owner_q  <= '0;
         rr_ptr_q <= N'(1);
      end else begin
         lock_q   <= lock_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign locked = lock_q;

`ifdef SW_ALLOC_STATS_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if ((|grant) && ($countones(eligible) > 1) && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign conflict_cnt = cnt_q;
`endif

endmodule

// File: rtl/sw_alloc_pkt_lock.sv
// rtl/sw_alloc_pkt_lock.sv - switch allocator top: per-input/per-output transposition around the arbiters
// SW_ALLOC_STATS_EN adds conflict_cnt_all.
module sw_alloc_pkt_lock
   import noc_alloc_pkg::*;
#(
   parameter int    P            = 5,
   parameter string SELF_LOOP_EN = "NO",
   parameter int    CNT_W        = 16,
   localparam bit   SL_YES       = (SELF_LOOP_EN == "YES"),
   localparam int   P_1          = calc_p_1(P, SL_YES)
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [P*P_1-1:0] dest_port_req_all,
   input  logic [P-1:0]     req_hdr_all,
   input  logic [P-1:0]     req_tail_all,
   input  logic [P-1:0]     out_ready_all,
   output logic [P*P_1-1:0] granted_dest_port_all,
   output logic [P-1:0]     any_grant_all,
   output logic [P-1:0]     out_locked_all
`ifdef SW_ALLOC_STATS_EN
   ,
   output logic [P*CNT_W-1:0] conflict_cnt_all
`endif
);

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   logic [P-1:0][P_1-1:0] out_req;
   logic [P-1:0][P_1-1:0] out_hdr;
   logic [P-1:0][P_1-1:0] out_tail;
   logic [P-1:0][P_1-1:0] out_gnt;

   for (genvar o = 0; o < P; o++) begin : g_out
      for (genvar j = 0; j < P; j++) begin : g_in
         if (SL_YES || (j != o)) begin : g_map
            // C: slot of input j among output o's candidates; B: slot of o in input j's vector.
            localparam int C = port_idx(o, j, SL_YES);
            localparam int B = port_idx(j, o, SL_YES);
            assign out_req[o][C]                     = dest_port_req_all[j*P_1 + B];
            assign out_hdr[o][C]                     = req_hdr_all[j];
            assign out_tail[o][C]                    = req_tail_all[j];
            assign granted_dest_port_all[j*P_1 + B]  = out_gnt[o][C];
         end
      end

      pkt_lock_rr_arbiter #(
         .N(P_1)
`ifdef SW_ALLOC_STATS_EN
         ,
         .CNT_W(CNT_W)
`endif
      ) u_arb (
         .clk    (clk),
         .reset  (reset),
         .req    (out_req[o]),
         .hdr    (out_hdr[o]),
         .tail   (out_tail[o]),
         .ready  (out_ready_all[o]),
         .grant  (out_gnt[o]),
         .locked (out_locked_all[o])
`ifdef SW_ALLOC_STATS_EN
         ,
         .conflict_cnt (conflict_cnt_all[o*CNT_W +: CNT_W])
`endif
      );
   end

   for (genvar j = 0; j < P; j++) begin : g_any
      assign any_grant_all[j] = |granted_dest_port_all[j*P_1 +: P_1];
   end

endmodule

// File: tb/tb_sw_alloc_pkt_lock.sv
// tb/tb_sw_alloc_pkt_lock.sv - directed scoreboard bench for sw_alloc_pkt_lock (P=5, SELF_LOOP_EN="NO")
// Counter checks are built when SW_ALLOC_STATS_EN is defined.
module tb_sw_alloc_pkt_lock;

   localparam int P   = 5;
   localparam int P_1 = 4;
   localparam int W   = P * P_1;
`ifdef SW_ALLOC_STATS_EN
   localparam int CW  = 4;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic [W-1:0]   dest;
   logic [P-1:0]   hdr;
   logic [P-1:0]   tail;
   logic [P-1:0]   ready;
   logic [W-1:0]   gnt;
   logic [P-1:0]   any_g;
   logic [P-1:0]   locked;
`ifdef SW_ALLOC_STATS_EN
   logic [P*CW-1:0] cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] q_gnt[$];
   logic [P-1:0] q_any[$];
   logic [P-1:0] q_lock[$];
   string        q_tag[$];

   always #5 clk = ~clk;

   sw_alloc_pkt_lock #(
      .P(P),
      .SELF_LOOP_EN("NO")
`ifdef SW_ALLOC_STATS_EN
      ,
      .CNT_W(CW)
`endif
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .dest_port_req_all     (dest),
      .req_hdr_all           (hdr),
      .req_tail_all          (tail),
      .out_ready_all         (ready),
      .granted_dest_port_all (gnt),
      .any_grant_all         (any_g),
      .out_locked_all        (locked)
`ifdef SW_ALLOC_STATS_EN
      ,
      .conflict_cnt_all      (cnt)
`endif
   );

   function automatic int enc(input int j, input int o);
      return j * P_1 + ((o > j) ? o - 1 : o);
   endfunction

   function automatic logic [W-1:0] gb(input int j, input int o);
      logic [W-1:0] v;
      v = '0;
      v[enc(j, o)] = 1'b1;
      return v;
   endfunction

   task automatic clr();
      dest = '0;
      hdr  = '0;
      tail = '0;
   endtask

   task automatic req(input int j, input int o, input bit h, input bit t);
      dest[enc(j, o)] = 1'b1;
      hdr[j]  = h;
      tail[j] = t;
   endtask

   task automatic cmp(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected values are queued with the drive, then popped at the negedge sample.
   task automatic chk(input logic [W-1:0] eg, input logic [P-1:0] ea,
                      input logic [P-1:0] el, input string tag);
      logic [W-1:0] xg;
      logic [P-1:0] xa;
      logic [P-1:0] xl;
      string        xt;
      q_gnt.push_back(eg);
      q_any.push_back(ea);
      q_lock.push_back(el);
      q_tag.push_back(tag);
      @(negedge clk);
      xg = q_gnt.pop_front();
      xa = q_any.pop_front();
      xl = q_lock.pop_front();
      xt = q_tag.pop_front();
      n_vec++;
      assert (gnt === xg) else begin
         n_err++;
         $error("FAIL %s.gnt: observed %h expected %h", xt, gnt, xg);
      end
      n_vec++;
      assert (any_g === xa) else begin
         n_err++;
         $error("FAIL %s.any: observed %b expected %b", xt, any_g, xa);
      end
      n_vec++;
      assert (locked === xl) else begin
         n_err++;
         $error("FAIL %s.locked: observed %b expected %b", xt, locked, xl);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1);
   end

   initial begin
      int jx;
      reset = 1'b0;
      ready = '1;
      clr();
      repeat (2) @(posedge clk);
      #1;

      chk('0, '0, '0, "rst_idle");
      req(1, 0, 1, 0);
      chk(gb(1, 0), 5'b00010, 5'b00000, "rst_comb_grant");
      clr();
      reset = 1'b1;

      // Two heads contend on output 0; lock holds input 1 until its tail.
      clr(); req(1, 0, 1, 0); req(2, 0, 1, 0);
      chk(gb(1, 0), 5'b00010, 5'b00000, "t1_h1");
      clr(); req(1, 0, 0, 1); req(2, 0, 1, 0);
      chk(gb(1, 0), 5'b00010, 5'b00001, "t1_t1");
      clr(); req(2, 0, 1, 0);
      chk(gb(2, 0), 5'b00100, 5'b00000, "t1_h2");
      clr(); req(2, 0, 0, 1);
      chk(gb(2, 0), 5'b00100, 5'b00001, "t1_t2");

      // 3-flit packet from input 3 blocks input 0's heads on output 4.
      clr(); req(0, 4, 1, 1);
      chk(gb(0, 4), 5'b00001, 5'b00000, "t2_pre");
      clr(); req(3, 4, 1, 0); req(0, 4, 1, 1);
      chk(gb(3, 4), 5'b01000, 5'b00000, "t2_h");
      clr(); req(3, 4, 0, 0); req(0, 4, 1, 1);
      chk(gb(3, 4), 5'b01000, 5'b10000, "t2_b");
      clr(); req(3, 4, 0, 1); req(0, 4, 1, 1);
      chk(gb(3, 4), 5'b01000, 5'b10000, "t2_t");
      clr(); req(0, 4, 1, 1);
      chk(gb(0, 4), 5'b00001, 5'b00000, "t2_after");

      // Output 2 stalled while locked to input 4.
      clr(); req(4, 2, 1, 0);
      chk(gb(4, 2), 5'b10000, 5'b00000, "t3_h");
      ready = 5'b11011;
      for (int i = 0; i < 3; i++) begin
         clr(); req(4, 2, 0, 0); req(0, 2, 1, 1);
         chk('0, 5'b00000, 5'b00100, "t3_stall");
      end
      ready = '1;
      clr(); req(4, 2, 0, 0); req(0, 2, 1, 1);
      chk(gb(4, 2), 5'b10000, 5'b00100, "t3_resume");
      clr(); req(4, 2, 0, 1); req(0, 2, 1, 1);
      chk(gb(4, 2), 5'b10000, 5'b00100, "t3_t");
      clr(); req(0, 2, 1, 1);
      chk(gb(0, 2), 5'b00001, 5'b00000, "t3_after");

      // Single-flit packets rotate 1,2,3 and never lock.
      clr();
      pulse_reset();
      for (int i = 0; i < 6; i++) begin
         jx = 1 + (i % 3);
         clr(); req(1, 0, 1, 1); req(2, 0, 1, 1); req(3, 0, 1, 1);
         chk(gb(jx, 0), 5'(1) << jx, 5'b00000, "t4_single");
      end

      // Reset in mid-packet drops the lock immediately.
      clr(); req(1, 2, 1, 0);
      chk(gb(1, 2), 5'b00010, 5'b00000, "t5_h");
      cmp(32'(locked), 32'h04, "t5_locked");
      reset = 1'b0;
      #1;
      cmp(32'(locked), 32'h00, "t5_async_clr");
      @(posedge clk);
      #1;
      reset = 1'b1;
      clr(); req(1, 2, 0, 0);
      chk('0, 5'b00000, 5'b00000, "t5_body_blocked");
      clr(); req(1, 2, 0, 0); req(3, 2, 1, 1);
      chk(gb(3, 2), 5'b01000, 5'b00000, "t5_new_head");

`ifdef SW_ALLOC_STATS_EN
      clr();
      pulse_reset();
      cmp(32'(cnt[1*CW +: CW]), 32'd0, "st_reset");
      for (int i = 0; i < 10; i++) begin
         jx = (i % 2 == 0) ? 0 : 2;
         clr(); req(0, 1, 1, 1); req(2, 1, 1, 1);
         chk(gb(jx, 1), 5'(1) << jx, 5'b00000, "st_contend");
      end
      cmp(32'(cnt[1*CW +: CW]), 32'd10, "st_cnt10");
      for (int i = 0; i < 10; i++) begin
         clr(); req(0, 1, 1, 1); req(2, 1, 1, 1);
         @(posedge clk);
         #1;
      end
      cmp(32'(cnt[1*CW +: CW]), 32'd15, "st_saturate");
      cmp(32'(cnt[0*CW +: CW]), 32'd0, "st_other_out");
`endif

      clr();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sw_alloc_pkt_lock.md
Name: sw_alloc_pkt_lock

Overview:
- Switch allocator that produces the per-input one-hot `granted_dest_port_all` vector consumed by the router crossbar.
- Uses the same P*P_1 sender-port-removed encoding as the crossbar.
- Holds one round-robin arbiter per output port and locks each output to one input for the length of a packet (head to tail).
- Sits between the input-port route/VC stage and the crossbar. Grants are combinational from registered arbitration state.

Parameters:
- P, 5: router port count.
- SELF_LOOP_EN, "NO": "NO" drops the self port from each request/grant vector (P_1=P-1); "YES" gives P_1=P.
- CNT_W, 16: statistics counter width (used only with the optional feature).

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-low reset.
- dest_port_req_all, in, P*P_1: per-input one-hot requested output, sender-port-removed encoding. At most one bit is set per input.
- req_hdr_all, in, P: the requesting flit of input i is a head flit.
- req_tail_all, in, P: the requesting flit of input i is a tail flit. Head and tail both set means a single-flit packet.
- out_ready_all, in, P: output o can accept one flit this cycle (credit available).
- granted_dest_port_all, out, P*P_1: per-input one-hot granted output, same encoding as the request vector.
- any_grant_all, out, P: input i was granted this cycle and pops its flit.
- out_locked_all, out, P: output o is currently locked to an owner.

Behaviour:
- Index mapping (SELF_LOOP_EN="NO"):
  - Input j's vector bit for output o is o-1 if o>j, else o.
  - Output o's candidate list holds inputs j≠o, compacted the same way.
  - With "YES", all mappings are identity.
- Per-output registered state:
  - lock (1 bit), owner (P_1-wide one-hot), rr_ptr (P_1-wide one-hot).
  - Reset values: lock=0, owner=0, rr_ptr=bit0.
- Outputs are combinational from inputs and state. Zero-cycle latency: the grant is valid in the same cycle as the request.
- Unlocked output o:
  - Eligible inputs are those requesting o with hdr=1.
  - If out_ready[o]=1, grant the first eligible input at or after rr_ptr, wrapping around.
  - A non-head request to an unlocked output is never granted.
- Locked output o:
  - Only the owner is eligible.
  - Grant when the owner requests o and out_ready[o]=1. All other requests, heads included, are blocked.
- State update on clk rising edge, only when o grants input g:
  - rr_ptr <= one position after g, wrapping around.
  - If hdr&!tail: lock<=1, owner<=g.
  - If tail: lock<=0, owner<=0.
  - Body flit (!hdr&!tail): state unchanged.
  - No grant: all state held.
- A single-flit packet (hdr&tail) never sets lock but does advance rr_ptr.
- out_ready[o]=0 stalls output o: no grant, state held, lock kept.
- Each input requests one output, so any_grant_all[i] = OR of granted_dest_port_all for input i. The result is one-hot or zero per input.
- Reset asserted mid-packet clears all locks immediately (asynchronous). The next cycle needs a fresh head to be granted.
- Simultaneous tail grant on o and a new head requesting o: the head waits one cycle. Grant is at most one per output per cycle.
- Outputs are fully determined during reset: lock=0, so out_locked_all=0. Grants still follow the combinational rules with reset state.

Optional Feature:
- Macro: SW_ALLOC_STATS_EN.
- Defined:
  - Adds output port `conflict_cnt_all` (P*CNT_W) with one saturating counter per output.
  - A counter increments on each cycle its output grants while at least 2 eligible requests are present.
  - Reset value 0. Saturates at all-ones.
- Undefined: the port and the counters do not exist. Allocation behaviour is identical.

Decomposition:
- Shared package (noc_alloc_pkg):
  - P_1 computation function.
  - Function mapping (input j, output o) to the compacted bit index for both SELF_LOOP_EN modes.
  - One-hot rotate-by-one helper.
- Sub-module: pkt_lock_rr_arbiter, one instance per output (P_1 requesters, lock/owner/rr_ptr state, ready gating).
- The top level handles only the index transposition between per-input and per-output views, plus the ORs.

Test Plan (P=5, SELF_LOOP_EN="NO"):
- Reset, then inputs 1 and 2 both head-request output 0 (bit0 set in each vector), all ready:
  - Cycle 0 grants input 1: granted bits [1*4+0]=1, any_grant=5'b00010.
  - Next cycle, input 1 sends a tail and input 2 is still at its head: grant input 1; then input 2 in the following cycle.
- Locked output: input 3 sends a 3-flit packet (H,B,T) to output 4 while input 0 head-requests output 4 every cycle:
  - Input 0 is granted only in the cycle after T.
  - out_locked_all[4]=1 during B and T.
- Stall: out_ready[2]=0 for 3 cycles while input 4 holds a body flit toward locked output 2:
  - No grants.
  - lock and owner unchanged.
  - Grant on the first ready cycle.
- Single-flit packets: inputs 1,2,3 each send hdr&tail to output 0 every cycle, starting with rr_ptr=bit0:
  - Grant order is 1,2,3,1,…
  - out_locked_all[0] is never 1.
- Reset mid-packet: assert reset after H to output 2. After release, a body request from the owner is not granted, and a new head from any input is granted.
- With SW_ALLOC_STATS_EN: a 10-cycle two-way contention on output 1 gives conflict_cnt_all[1]=10. Force the count to all-ones and verify it holds.
